// File: rtl/edge_stim_pkg.sv
// Shared types and defaults for the delayed-edge stimulus generator.
// Optional feature macro: EDGE_STIM_PULSE_EN (see edge_stim_chan).
package edge_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HIGH  = 2'd2
    } stim_state_e;

    localparam int NCH_DEF = 2;
    localparam int DW_DEF  = 16;

endpackage

// File: rtl/edge_stim_chan.sv
// One channel of the delayed-edge source: IDLE -> COUNT (load delay) -> HIGH.
// With delay D loaded at edge n, the output rises after edge n+D+1.
// Macro EDGE_STIM_PULSE_EN: when defined, HIGH lasts a single cycle and the
// channel returns to IDLE on its own; otherwise HIGH holds until clr.
module edge_stim_chan
    import edge_stim_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          kick,
    input  logic          clr,
    input  logic [DW-1:0] delay,
    output logic          sig,
    output logic          busy,
    output logic          done
);

    stim_state_e   state_reg, state_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic          done_reg, done_next;

    // State, counter and done-strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic; a kick always wins over clr except in HIGH, where a
    // lone kick is ignored and kick+clr restarts the count.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (kick) begin
                    state_next = COUNT;
                    cnt_next   = delay;
                end
            end
            COUNT: begin
                if (kick) begin
                    cnt_next = delay;
                end else if (clr) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg != '0) begin
                    // Gated by cnt != 0, so the counter never wraps.
                    cnt_next = cnt_reg - DW'(1);
                end else begin
                    state_next = HIGH;
                    done_next  = 1'b1;
                end
            end
            HIGH: begin
                if (kick && clr) begin
                    state_next = COUNT;
                    cnt_next   = delay;
                end else if (clr) begin
                    state_next = IDLE;
                end
`ifdef EDGE_STIM_PULSE_EN
                else begin
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign sig  = (state_reg == HIGH);
    assign busy = (state_reg == COUNT);
    assign done = done_reg;

endmodule

// File: rtl/edge_stim_gen.sv
// Multi-channel delayed-edge source: NCH independent channels, each raising
// sig_o[i] a programmed number of cycles after kick_i[i].
// Macro EDGE_STIM_PULSE_EN selects one-cycle pulse output instead of a level.
module edge_stim_gen
    import edge_stim_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NCH-1:0]    kick_i,
    input  logic [NCH*DW-1:0] delay_i,
    input  logic [NCH-1:0]    clr_i,
    output logic [NCH-1:0]    sig_o,
    output logic [NCH-1:0]    busy_o,
    output logic [NCH-1:0]    done_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            edge_stim_chan #(
                .DW(DW)
            ) u_chan (
                .clk   (clk_i),
                .rst_n (rst_n_i),
                .kick  (kick_i[gi]),
                .clr   (clr_i[gi]),
                .delay (delay_i[gi*DW +: DW]),
                .sig   (sig_o[gi]),
                .busy  (busy_o[gi]),
                .done  (done_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_edge_stim_gen.sv
// Self-checking bench for edge_stim_gen. A deadline-based model predicts each
// channel's outputs every cycle; directed tests pin latencies with literals.
// Honours EDGE_STIM_PULSE_EN when the design is built with it.
module tb_edge_stim_gen;
    import edge_stim_pkg::*;

    localparam int NCH = 2;
    localparam int DW  = 16;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    kick  = '0;
    logic [NCH-1:0]    clr   = '0;
    logic [NCH*DW-1:0] delay = '0;
    logic [NCH-1:0]    sig;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;

    always #5 clk = ~clk;

    edge_stim_gen #(.NCH(NCH), .DW(DW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .kick_i  (kick),
        .delay_i (delay),
        .clr_i   (clr),
        .sig_o   (sig),
        .busy_o  (busy),
        .done_o  (done)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: a counting channel is described by the edge number at which it
    // will go high (deadline); -1 means not counting.
    longint cyc;
    longint deadline [NCH];
    bit     m_high   [NCH];
    bit     m_done   [NCH];
    longint dl;
    bit     pulse_mode;
    bit     cmp_en = 1'b0;
    int     done_cnt [NCH];

    initial begin
`ifdef EDGE_STIM_PULSE_EN
        pulse_mode = 1'b1;
`else
        pulse_mode = 1'b0;
`endif
        for (int ch = 0; ch < NCH; ch++) done_cnt[ch] = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                deadline[ch] = -1;
                m_high[ch]   = 1'b0;
                m_done[ch]   = 1'b0;
            end
        end else begin
            cyc++;
            for (int ch = 0; ch < NCH; ch++) begin
                dl = longint'(delay[ch*DW +: DW]);
                m_done[ch] = 1'b0;
                if (kick[ch] && (!m_high[ch] || clr[ch])) begin
                    deadline[ch] = cyc + dl + 1;
                    m_high[ch]   = 1'b0;
                end else if (clr[ch]) begin
                    deadline[ch] = -1;
                    m_high[ch]   = 1'b0;
                end else if (m_high[ch] && pulse_mode) begin
                    m_high[ch] = 1'b0;
                end else if (deadline[ch] == cyc) begin
                    m_high[ch]   = 1'b1;
                    m_done[ch]   = 1'b1;
                    deadline[ch] = -1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            for (int ch = 0; ch < NCH; ch++) begin
                chk($sformatf("busy[%0d]@%0d", ch, cyc), longint'(busy[ch]), longint'(deadline[ch] != -1));
                chk($sformatf("sig[%0d]@%0d", ch, cyc), longint'(sig[ch]), longint'(m_high[ch]));
                chk($sformatf("done[%0d]@%0d", ch, cyc), longint'(done[ch]), longint'(m_done[ch]));
                if (done[ch]) done_cnt[ch]++;
            end
        end
    end

    task automatic tick(input logic [NCH-1:0] k, input logic [NCH-1:0] c);
        @(negedge clk);
        kick = k;
        clr  = c;
        @(posedge clk);
        #2;
    endtask

    task automatic set_delay(input int ch, input logic [DW-1:0] v);
        delay[ch*DW +: DW] = v;
    endtask

    // Edges after the last tick until sig[ch] is seen high; -1 on timeout.
    task automatic wait_rise(input int ch, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick('0, '0);
            if (sig[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    int n, r0, r1, d0, d1, rises;

    initial begin
        cmp_en = 1'b1;
        // Reset held for 3 cycles with kicks applied.
        set_delay(0, 16'd3);
        set_delay(1, 16'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            kick = 2'b11;
            @(posedge clk);
            #2;
            chk("reset_sig", longint'(sig), 0);
            chk("reset_busy", longint'(busy), 0);
            chk("reset_done", longint'(done), 0);
        end
        @(negedge clk);
        kick  = '0;
        rst_n = 1'b1;
        tick('0, '0);
        tick('0, '0);
        chk("post_reset_busy", longint'(busy), 0);
        chk("post_reset_sig", longint'(sig), 0);

        // Basic latency: ch0 D=0, ch1 D=5.
        set_delay(0, 16'd0);
        set_delay(1, 16'd5);
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        tick(2'b11, '0);
        r0 = -1;
        r1 = -1;
        for (int k = 1; k <= 20; k++) begin
            tick('0, '0);
            if (r0 < 0 && sig[0]) r0 = k;
            if (r1 < 0 && sig[1]) r1 = k;
        end
        chk("lat_ch0", r0, 1);
        chk("lat_ch1", r1, 6);
        chk("done_cnt_ch0", done_cnt[0] - d0, 1);
        chk("done_cnt_ch1", done_cnt[1] - d1, 1);
        tick('0, 2'b11);
        tick('0, '0);

        // Restart: D=8 at edge 0, re-kick with D=3 at edge 4.
        set_delay(0, 16'd8);
        d0 = done_cnt[0];
        tick(2'b01, '0);
        for (int k = 0; k < 3; k++) tick('0, '0);
        set_delay(0, 16'd3);
        tick(2'b01, '0);
        wait_rise(0, 20, n);
        chk("restart_rise", (n < 0) ? -1 : n + 4, 8);
        chk("restart_done", done_cnt[0] - d0, 1);
        tick('0, 2'b01);

        // Abort: ch1 D=10, clr at edge 5.
        set_delay(1, 16'd10);
        tick(2'b10, '0);
        for (int k = 0; k < 4; k++) tick('0, '0);
        tick('0, 2'b10);
        chk("abort_busy", longint'(busy[1]), 0);
        chk("abort_sig", longint'(sig[1]), 0);
        rises = 0;
        for (int k = 0; k < 15; k++) begin
            tick('0, '0);
            if (sig[1]) rises++;
        end
        chk("abort_no_rise", rises, 0);

        // Clear while HIGH.
        set_delay(1, 16'd1);
        tick(2'b10, '0);
        wait_rise(1, 10, n);
        chk("clr_high_rise", n, 2);
`ifndef EDGE_STIM_PULSE_EN
        tick(2'b10, '0);
        chk("kick_in_high_ignored", longint'(sig[1]), 1);
`endif
        tick('0, 2'b10);
        chk("clr_high_sig", longint'(sig[1]), 0);
        chk("clr_high_busy", longint'(busy[1]), 0);

        // Kick and clr together in HIGH, ch0 D=2.
        set_delay(0, 16'd2);
        tick(2'b01, '0);
        wait_rise(0, 10, n);
        chk("kc_first_rise", n, 3);
        tick('0, '0);
        tick(2'b01, 2'b01);
        chk("kc_sig_drop", longint'(sig[0]), 0);
        chk("kc_busy", longint'(busy[0]), 1);
        wait_rise(0, 10, n);
        chk("kc_second_rise", n, 3);
        tick('0, 2'b01);

        // Full-range delay on ch1.
        set_delay(1, 16'hFFFF);
        tick(2'b10, '0);
        wait_rise(1, 70000, n);
        chk("full_range_rise", n, 65536);
        tick('0, 2'b10);

        // Reset mid-count.
        set_delay(0, 16'd20);
        tick(2'b01, '0);
        tick('0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", longint'(busy), 0);
        chk("midreset_sig", longint'(sig), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        for (int k = 0; k < 25; k++) begin
            tick('0, '0);
            if (sig[0] || busy[0]) rises++;
        end
        chk("midreset_stays_idle", rises, 0);

`ifdef EDGE_STIM_PULSE_EN
        // Pulse mode: one-cycle sig, back to IDLE.
        set_delay(0, 16'd4);
        tick(2'b01, '0);
        wait_rise(0, 10, n);
        chk("pulse_rise", n, 5);
        chk("pulse_done", longint'(done[0]), 1);
        tick('0, '0);
        chk("pulse_sig_low", longint'(sig[0]), 0);
        chk("pulse_busy_low", longint'(busy[0]), 0);
`endif

        tick('0, '0);
        cmp_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
